gmii_tx_engine: RTL and testbench

- Transmit half of a lightweight 1G MAC: responds to the client byte interface (tx_data/tx_dvld/tx_ack) that the tx queue drives.
- Adds preamble and SFD, pads short frames, appends CRC-32 FCS and enforces inter-frame gap.
- Drives GMII transmit pins directly; replaces the vendor MAC transmit path in the MAC group.

---
 rtl/gmii_tx_pkg.sv | 29 ++
 rtl/crc32_d8.sv | 19 +
 rtl/gmii_tx_engine.sv | 211 +++++++++++++++++++++
 tb/tb_gmii_tx_engine.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmii_tx_pkg.sv
// Shared constants, state encoding and helpers for the GMII transmit path
// and the companion receive checker.
package gmii_tx_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [7:0]  PREAMBLE_LEN  = 8'd8;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_PAD,
    S_FCS,
    S_DRAIN,
    S_IFG
  } tx_state_t;

  function automatic logic [13:0] sat_add14(input logic [13:0] a, input logic [13:0] b);
    logic [14:0] w_sum;
    w_sum = {1'b0, a} + {1'b0, b};
    return w_sum[14] ? 14'h3FFF : w_sum[13:0];
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational IEEE 802.3 CRC-32 step over one byte, LSB first (reflected form).
module crc32_d8 (
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);
  import gmii_tx_pkg::*;

  logic [31:0] w_crc;

  always_comb begin
    w_crc = i_crc;
    for (int i = 0; i < 8; i++) begin
      w_crc = {1'b0, w_crc[31:1]} ^ ({32{w_crc[0] ^ i_data[i]}} & CRC_POLY_REFL);
    end
    o_crc = w_crc;
  end

endmodule

// File: rtl/gmii_tx_engine.sv
// GMII transmit engine: preamble/SFD, padding, FCS append, underrun/oversize
// abort and inter-frame gap. All GMII and status outputs come straight from flops.
module gmii_tx_engine #(
  parameter int MIN_FRAME = 60,
  parameter int MAX_FRAME = 1514,
  parameter int MAX_JUMBO = 9014,
  parameter int MIN_IFG   = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  tx_data,
  input  logic        tx_dvld,
  output logic        tx_ack,
  input  logic        tx_underrun,
  input  logic        tx_enable,
  input  logic        disable_crc_gen,
  input  logic        enable_jumbo,
  input  logic [7:0]  ifg_delay,
  output logic [7:0]  gmii_tx_d,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic        tx_frame_sent,
  output logic        tx_frame_err,
  output logic [13:0] tx_byte_cnt
);
  import gmii_tx_pkg::*;

  tx_state_t   r_state, w_state_n;
  logic [7:0]  r_cnt, w_cnt_n;
  logic [13:0] r_byte_cnt, w_byte_cnt_n;
  logic [31:0] r_crc, w_crc_n, w_crc_fold;
  logic        r_use_crc, w_use_crc_n;
  logic        r_jumbo, w_jumbo_n;

  logic [7:0]  r_tx_d, w_tx_d_n;
  logic        r_tx_en, w_tx_en_n, r_tx_er, w_tx_er_n;
  logic        r_ack, w_ack_n, r_sent, w_sent_n, r_err, w_err_n;
  logic [13:0] r_out_cnt, w_out_cnt_n;

  logic        w_accept;
  logic [7:0]  w_fold_byte, w_gap;
  logic [13:0] w_limit;

  // Byte0 is taken on the edge that ends the SFD cycle, then once per DATA cycle.
  assign w_accept    = (r_state == S_DATA) || (r_state == S_PREAMBLE && r_cnt == PREAMBLE_LEN);
  assign w_fold_byte = (tx_dvld && (r_state == S_PREAMBLE || r_state == S_DATA)) ? tx_data : 8'h00;
  assign w_gap       = (ifg_delay < 8'(MIN_IFG)) ? 8'(MIN_IFG) : ifg_delay;
  assign w_limit     = r_jumbo ? 14'(MAX_JUMBO) : 14'(MAX_FRAME);

  crc32_d8 u_crc (
    .i_crc  (r_crc),
    .i_data (w_fold_byte),
    .o_crc  (w_crc_fold)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_byte_cnt <= '0;
      r_crc      <= CRC_INIT;
      r_use_crc  <= 1'b0;
      r_jumbo    <= 1'b0;
      r_tx_d     <= '0;
      r_tx_en    <= 1'b0;
      r_tx_er    <= 1'b0;
      r_ack      <= 1'b0;
      r_sent     <= 1'b0;
      r_err      <= 1'b0;
      r_out_cnt  <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of its peers.
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_byte_cnt <= w_byte_cnt_n;
      r_crc      <= w_crc_n;
      r_use_crc  <= w_use_crc_n;
      r_jumbo    <= w_jumbo_n;
      r_tx_d     <= w_tx_d_n;
      r_tx_en    <= w_tx_en_n;
      r_tx_er    <= w_tx_er_n;
      r_ack      <= w_ack_n;
      r_sent     <= w_sent_n;
      r_err      <= w_err_n;
      r_out_cnt  <= w_out_cnt_n;
    end
  end

  always_comb begin
    // NOTE: hold-value defaults first, so no path through the case can infer a latch.
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_byte_cnt_n = r_byte_cnt;
    w_crc_n      = r_crc;
    w_use_crc_n  = r_use_crc;
    w_jumbo_n    = r_jumbo;
    case (r_state)
      S_IDLE, S_IFG: begin
        if (r_state == S_IFG && r_cnt < w_gap) begin
          w_cnt_n = r_cnt + 8'd1;
        end else if (tx_dvld && tx_enable) begin
          w_state_n    = S_PREAMBLE;
          w_cnt_n      = 8'd1;
          w_byte_cnt_n = '0;
          w_crc_n      = CRC_INIT;
          w_use_crc_n  = !disable_crc_gen;
          w_jumbo_n    = enable_jumbo;
        end else begin
          w_state_n = S_IDLE;
        end
      end
      S_PREAMBLE, S_DATA: begin
        if (tx_underrun) begin
          w_state_n = S_DRAIN;
        end else if (!w_accept) begin
          w_cnt_n = r_cnt + 8'd1;
        end else if (tx_dvld) begin
          w_byte_cnt_n = r_byte_cnt + 14'd1;
          if (r_byte_cnt >= w_limit) begin
            w_state_n = S_DRAIN;
          end else begin
            w_state_n = S_DATA;
            w_crc_n   = w_crc_fold;
          end
        end else if (r_use_crc && r_byte_cnt < 14'(MIN_FRAME)) begin
          w_state_n    = S_PAD;
          w_byte_cnt_n = r_byte_cnt + 14'd1;
          w_crc_n      = w_crc_fold;
        end else if (r_use_crc) begin
          w_state_n = S_FCS;
          w_cnt_n   = '0;
        end else begin
          w_state_n = S_IFG;
          w_cnt_n   = 8'd1;
        end
      end
      S_PAD: begin
        if (r_byte_cnt < 14'(MIN_FRAME)) begin
          w_byte_cnt_n = r_byte_cnt + 14'd1;
          w_crc_n      = w_crc_fold;
        end else begin
          w_state_n = S_FCS;
          w_cnt_n   = '0;
        end
      end
      S_FCS: begin
        if (r_cnt == 8'd3) begin
          w_state_n = S_IFG;
          w_cnt_n   = 8'd1;
        end else begin
          w_cnt_n = r_cnt + 8'd1;
        end
      end
      S_DRAIN: begin
        if (!tx_dvld) begin
          w_state_n = S_IFG;
          w_cnt_n   = 8'd1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Outputs are decoded from the transition, so the flops show this cycle's decision next cycle.
  always_comb begin
    w_tx_d_n    = 8'h00;
    w_tx_en_n   = 1'b0;
    w_tx_er_n   = 1'b0;
    w_ack_n     = 1'b0;
    w_sent_n    = 1'b0;
    w_err_n     = 1'b0;
    w_out_cnt_n = r_out_cnt;
    case (w_state_n)
      S_PREAMBLE: begin
        w_tx_en_n = 1'b1;
        w_ack_n   = (w_cnt_n == PREAMBLE_LEN);
        w_tx_d_n  = w_ack_n ? SFD_BYTE : PREAMBLE_BYTE;
      end
      S_DATA: begin
        w_tx_en_n = 1'b1;
        w_tx_d_n  = tx_data;
      end
      S_PAD: w_tx_en_n = 1'b1;
      S_FCS: begin
        w_tx_en_n = 1'b1;
        w_tx_d_n  = ~r_crc[{w_cnt_n[1:0], 3'b000} +: 8];
        w_sent_n  = (w_cnt_n == 8'd3);
      end
      S_DRAIN: begin
        if (r_state != S_DRAIN) begin
          w_tx_en_n = 1'b1;
          w_tx_er_n = 1'b1;
          w_err_n   = 1'b1;
        end
      end
      S_IFG: w_sent_n = (r_state == S_DATA || r_state == S_PREAMBLE);
      default: ;
    endcase
    if (w_sent_n) w_out_cnt_n = sat_add14(r_byte_cnt, r_use_crc ? 14'd4 : 14'd0);
    if (w_err_n)  w_out_cnt_n = w_byte_cnt_n;
  end

  assign gmii_tx_d     = r_tx_d;
  assign gmii_tx_en    = r_tx_en;
  assign gmii_tx_er    = r_tx_er;
  assign tx_ack        = r_ack;
  assign tx_frame_sent = r_sent;
  assign tx_frame_err  = r_err;
  assign tx_byte_cnt   = r_out_cnt;

endmodule

// File: tb/tb_gmii_tx_engine.sv
// Directed bench for gmii_tx_engine: a byte-level client, a wire monitor and
// a software CRC model that also checks the receiver residue.
module tb_gmii_tx_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  tx_data;
  logic        tx_dvld;
  logic        tx_ack;
  logic        tx_underrun;
  logic        tx_enable;
  logic        disable_crc_gen;
  logic        enable_jumbo;
  logic [7:0]  ifg_delay;
  logic [7:0]  gmii_tx_d;
  logic        gmii_tx_en;
  logic        gmii_tx_er;
  logic        tx_frame_sent;
  logic        tx_frame_err;
  logic [13:0] tx_byte_cnt;

  always #4 clk = ~clk;

  gmii_tx_engine dut (
    .clk             (clk),
    .reset           (reset),
    .tx_data         (tx_data),
    .tx_dvld         (tx_dvld),
    .tx_ack          (tx_ack),
    .tx_underrun     (tx_underrun),
    .tx_enable       (tx_enable),
    .disable_crc_gen (disable_crc_gen),
    .enable_jumbo    (enable_jumbo),
    .ifg_delay       (ifg_delay),
    .gmii_tx_d       (gmii_tx_d),
    .gmii_tx_en      (gmii_tx_en),
    .gmii_tx_er      (gmii_tx_er),
    .tx_frame_sent   (tx_frame_sent),
    .tx_frame_err    (tx_frame_err),
    .tx_byte_cnt     (tx_byte_cnt)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] fb [0:2047];

  // Wire monitor: cap holds the bytes of the most recent tx_en burst.
  logic [7:0] cap [$];
  logic mon_prev_en = 1'b0;
  int mon_gap_run = 0, mon_last_gap = 0, mon_frames = 0;
  int mon_er = 0, mon_er_pos = 0, mon_sent = 0, mon_sent_pos = 0, mon_err = 0;
  int b_er, b_sent, b_err, b_frames;

  always @(negedge clk) begin
    if (gmii_tx_en) begin
      if (!mon_prev_en) begin
        cap.delete();
        mon_last_gap <= mon_gap_run;
        mon_frames   <= mon_frames + 1;
      end
      cap.push_back(gmii_tx_d);
    end else begin
      mon_gap_run <= mon_prev_en ? 1 : mon_gap_run + 1;
    end
    if (gmii_tx_er) begin
      mon_er     <= mon_er + 1;
      mon_er_pos <= cap.size();
    end
    if (tx_frame_sent) begin
      mon_sent     <= mon_sent + 1;
      mon_sent_pos <= cap.size();
    end
    if (tx_frame_err) mon_err <= mon_err + 1;
    mon_prev_en <= gmii_tx_en;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] reflect32(input logic [31:0] c);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = c[31-i];
    return r;
  endfunction

  function automatic int preamble_bad();
    int bad = 0;
    if (cap.size() < 8) return 99;
    for (int i = 0; i < 7; i++) if (cap[i] != 8'h55) bad++;
    if (cap[7] != 8'hD5) bad++;
    return bad;
  endfunction

  function automatic int data_bad(input int n);
    int bad = 0;
    if (cap.size() < 8 + n) return 99;
    for (int i = 0; i < n; i++) if (cap[8+i] != fb[i]) bad++;
    return bad;
  endfunction

  function automatic int pad_bad(input int n);
    int bad = 0;
    if (cap.size() < 68) return 99;
    for (int i = n; i < 60; i++) if (cap[8+i] != 8'h00) bad++;
    return bad;
  endfunction

  function automatic int fcs_bad(input int n);
    logic [31:0] c;
    int len, bad;
    c   = 32'hFFFFFFFF;
    len = (n < 60) ? 60 : n;
    bad = 0;
    for (int i = 0; i < len; i++) c = crc_upd(c, (i < n) ? fb[i] : 8'h00);
    c = ~c;
    if (cap.size() != 8 + len + 4) return 99;
    for (int j = 0; j < 4; j++) if (cap[8+len+j] != c[8*j +: 8]) bad++;
    return bad;
  endfunction

  function automatic logic [31:0] residue();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 8; i < cap.size(); i++) c = crc_upd(c, cap[i]);
    return reflect32(c);
  endfunction

  task automatic snap();
    b_er = mon_er; b_sent = mon_sent; b_err = mon_err; b_frames = mon_frames;
  endtask

  // Client side: byte0 waits on the bus for tx_ack, then one byte per cycle.
  task automatic send_frame(input int n, input int underrun_at);
    int t = 0;
    @(negedge clk);
    tx_dvld = 1'b1;
    tx_data = fb[0];
    while (!tx_ack && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("ack_timeout", 32'(t >= 200), 0);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == underrun_at) begin
        tx_underrun = 1'b1;
        @(negedge clk);
        tx_underrun = 1'b0;
        tx_dvld     = 1'b0;
        break;
      end
      if (k == n) tx_dvld = 1'b0;
      else        tx_data = fb[k];
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while (gmii_tx_en && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check("done_timeout", 32'(t >= 4000), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; tx_data = 8'h00; tx_dvld = 1'b0; tx_underrun = 1'b0; tx_enable = 1'b1;
    disable_crc_gen = 1'b0; enable_jumbo = 1'b0; ifg_delay = 8'd12;
    repeat (3) @(negedge clk);
    check("rst_d", gmii_tx_d, 0);
    check("rst_en", gmii_tx_en, 0);
    check("rst_er", gmii_tx_er, 0);
    check("rst_ack", tx_ack, 0);
    check("rst_sent", tx_frame_sent, 0);
    check("rst_err", tx_frame_err, 0);
    check("rst_cnt", tx_byte_cnt, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 60-byte frame, exactly minimum size
    for (int i = 0; i < 60; i++) fb[i] = 8'(i);
    snap();
    send_frame(60, -1);
    wait_done();
    check("f60_len", cap.size(), 72);
    check("f60_pre", preamble_bad(), 0);
    check("f60_data", data_bad(60), 0);
    check("f60_fcs", fcs_bad(60), 0);
    check("f60_res", residue(), 32'hC704DD7B);
    check("f60_sent", mon_sent - b_sent, 1);
    check("f60_sent_pos", mon_sent_pos, 72);
    check("f60_err", mon_err - b_err, 0);
    check("f60_cnt", tx_byte_cnt, 64);

    // no-CRC 64-byte frame
    for (int i = 0; i < 64; i++) fb[i] = 8'(8'hC3 ^ 8'(i * 7));
    disable_crc_gen = 1'b1;
    snap();
    send_frame(64, -1);
    wait_done();
    disable_crc_gen = 1'b0;
    check("nocrc_len", cap.size(), 72);
    check("nocrc_data", data_bad(64), 0);
    check("nocrc_sent", mon_sent - b_sent, 1);
    check("nocrc_cnt", tx_byte_cnt, 64);

    // back-to-back: gap floors at MIN_IFG, then follows ifg_delay
    for (int i = 0; i < 20; i++) fb[i] = 8'(8'h10 + i);
    ifg_delay = 8'd5;
    send_frame(20, -1);
    send_frame(20, -1);
    wait_done();
    check("gap_floor", mon_last_gap, 12);
    ifg_delay = 8'd20;
    send_frame(20, -1);
    send_frame(20, -1);
    wait_done();
    check("gap_20", mon_last_gap, 20);
    ifg_delay = 8'd12;

    // underrun at byte 30
    for (int i = 0; i < 50; i++) fb[i] = 8'(8'h80 + i);
    snap();
    send_frame(50, 30);
    wait_done();
    check("urun_len", cap.size(), 39);
    check("urun_er", mon_er - b_er, 1);
    check("urun_er_pos", mon_er_pos, 39);
    check("urun_err", mon_err - b_err, 1);
    check("urun_sent", mon_sent - b_sent, 0);
    check("urun_cnt", tx_byte_cnt, 30);

    // 1515 bytes, jumbo off: oversize abort on the 1515th byte
    for (int i = 0; i < 1515; i++) fb[i] = 8'(i) ^ 8'h5A;
    snap();
    send_frame(1515, -1);
    wait_done();
    repeat (15) @(negedge clk);
    check("ovr_len", cap.size(), 1523);
    check("ovr_er_pos", mon_er_pos, 1523);
    check("ovr_er", mon_er - b_er, 1);
    check("ovr_err", mon_err - b_err, 1);
    check("ovr_sent", mon_sent - b_sent, 0);
    check("ovr_cnt", tx_byte_cnt, 1515);
    check("ovr_idle_en", gmii_tx_en, 0);

    // same frame, jumbo on
    enable_jumbo = 1'b1;
    snap();
    send_frame(1515, -1);
    wait_done();
    enable_jumbo = 1'b0;
    check("jmb_len", cap.size(), 1527);
    check("jmb_data", data_bad(1515), 0);
    check("jmb_fcs", fcs_bad(1515), 0);
    check("jmb_res", residue(), 32'hC704DD7B);
    check("jmb_sent", mon_sent - b_sent, 1);
    check("jmb_err", mon_err - b_err, 0);
    check("jmb_cnt", tx_byte_cnt, 1519);

    // tx_enable low holds the engine idle
    snap();
    tx_enable = 1'b0;
    @(negedge clk);
    tx_dvld = 1'b1;
    repeat (40) @(negedge clk);
    check("hold_frames", mon_frames - b_frames, 0);
    check("hold_en", gmii_tx_en, 0);
    tx_dvld   = 1'b0;
    tx_enable = 1'b1;
    repeat (2) @(negedge clk);

    // reset mid-frame drops tx_en at once, no error pulse
    tx_dvld = 1'b1;
    repeat (20) @(negedge clk);
    check("mid_en_before", gmii_tx_en, 1);
    reset = 1'b1;
    #1;
    check("mid_en", gmii_tx_en, 0);
    check("mid_er", gmii_tx_er, 0);
    check("mid_err", tx_frame_err, 0);
    check("mid_cnt", tx_byte_cnt, 0);
    tx_dvld = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 14-byte frame padded to 60
    for (int i = 0; i < 14; i++) fb[i] = 8'(8'hA0 + i);
    snap();
    send_frame(14, -1);
    wait_done();
    check("pad_len", cap.size(), 72);
    check("pad_pre", preamble_bad(), 0);
    check("pad_data", data_bad(14), 0);
    check("pad_zero", pad_bad(14), 0);
    check("pad_fcs", fcs_bad(14), 0);
    check("pad_res", residue(), 32'hC704DD7B);
    check("pad_sent", mon_sent - b_sent, 1);
    check("pad_cnt", tx_byte_cnt, 64);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
